// File: rtl/inputc_pkg.sv
// Shared definitions for the router input channel: flit type encoding, field
// positions, VC and FIFO sizing, and small flit decode helpers.
package inputc_pkg;

  localparam int DATAW    = 15;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 13;
  localparam int VCH      = 1;
  localparam int VCHW     = 0;
  localparam int FIFO_P1  = 4;
  localparam int FIFOD_P1 = 2;

  localparam logic Enable  = 1'b1;
  localparam logic Enable_ = 1'b0;

  typedef enum logic [2:0] {
    TYPE_NONE     = 3'd0,
    TYPE_HEAD     = 3'd1,
    TYPE_BODY     = 3'd2,
    TYPE_TAIL     = 3'd3,
    TYPE_HEADTAIL = 3'd4
  } flit_type_e;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  function automatic flit_type_e flit_type(input logic [DATAW:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
  endfunction

  function automatic logic is_cont(input flit_type_e t);
    return (t == TYPE_BODY) || (t == TYPE_TAIL);
  endfunction

endpackage

// File: rtl/inputc_fifo.sv
// Single-VC synchronous FIFO with occupancy count; writes to a full FIFO and
// reads from an empty one are ignored. Head entry is read combinationally.
module inputc_fifo
  import inputc_pkg::*;
#(
  parameter int DEPTH = FIFO_P1,
  parameter int W     = DATAW + 1,
  parameter int PW    = FIFOD_P1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [PW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          wr_s, rd_s;

  always_comb begin
    wr_s     = wr_en_i && !full_o;
    rd_s     = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {(PW + 1){1'b0}});

endmodule

// File: rtl/inputc.sv
// Router input channel: per-VC flit FIFOs, packet FSM, credit acks and VC lock.
// Define INPUTC_ERRCHK_EN to build the sticky protocol error flag on oerr.
module inputc
  import inputc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int DEPTH    = FIFO_P1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [DATAW:0]  idata,
  input  logic            ivalid,
  input  logic [VCHW:0]   ivch,
  input  logic [VCH:0]    ilck,
  output logic [VCH:0]    olck,
  output logic [VCH:0]    oack,
  output logic [DATAW:0]  odata0,
  output logic [DATAW:0]  odata1,
  output logic [VCH:0]    ovalid,
  output logic [VCH:0]    ohead,
  input  logic [VCH:0]    ideq,
  output logic            oerr
);

  localparam int NVC = VCH + 1;

  if ((DEPTH < 1) || (DEPTH > (1 << FIFOD_P1)) || (ROUTERID < 0) || (PCHID < 0)) begin : g_bad_param
    $error("inputc: unsupported parameter value");
  end

  logic [NVC-1:0][DATAW:0]    head_data_s;
  logic [NVC-1:0][FIFOD_P1:0] count_s;
  logic [VCH:0]               full_s, empty_s;
  logic [VCH:0]               wr_s, deq_s;
  flit_type_e                 head_type_s [NVC];
  vc_state_e                  state_q [NVC];
  logic [VCH:0]               olck_q, oack_q;
  logic                       unused_cnt_s;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    inputc_fifo #(
      .DEPTH (DEPTH),
      .W     (DATAW + 1),
      .PW    (FIFOD_P1)
    ) u_fifo (
      .clk     (clk),
      .rst_    (rst_),
      .wr_en_i (wr_s[v]),
      .rd_en_i (deq_s[v]),
      .wdata_i (idata),
      .rdata_o (head_data_s[v]),
      .count_o (count_s[v]),
      .full_o  (full_s[v]),
      .empty_o (empty_s[v])
    );
  end

  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      wr_s[v]        = ivalid && (ivch == (VCHW + 1)'(v));
      deq_s[v]       = ideq[v] && !empty_s[v];
      head_type_s[v] = flit_type(head_data_s[v]);
      ohead[v]       = !empty_s[v] && (state_q[v] == VC_IDLE) && is_head(head_type_s[v]);
    end
  end

  // Packet FSM, credit return and lock state per VC.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= VC_IDLE;
      end
      oack_q <= {NVC{1'b0}};
      olck_q <= {NVC{1'b0}};
    end else begin
      oack_q <= deq_s;
      for (int v = 0; v < NVC; v++) begin
        if (deq_s[v]) begin
          case (head_type_s[v])
            TYPE_HEAD: state_q[v] <= VC_ACTIVE;
            TYPE_TAIL: state_q[v] <= VC_IDLE;
            default:   state_q[v] <= state_q[v];
          endcase
        end
        if (wr_s[v] || !empty_s[v] || (state_q[v] == VC_ACTIVE)) begin
          olck_q[v] <= 1'b1;
        end else if (!ilck[v]) begin
          olck_q[v] <= 1'b0;
        end
      end
    end
  end

  assign oack   = oack_q;
  assign olck   = olck_q;
  assign ovalid = ~empty_s;
  assign odata0 = head_data_s[0];
  assign odata1 = head_data_s[1];

  assign unused_cnt_s = ^count_s;

`ifdef INPUTC_ERRCHK_EN
  logic [VCH:0] err_s;
  logic         err_q;

  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      err_s[v] = (wr_s[v] && full_s[v])
              || (deq_s[v] && (state_q[v] == VC_IDLE)   && is_cont(head_type_s[v]))
              || (deq_s[v] && (state_q[v] == VC_ACTIVE) && is_head(head_type_s[v]));
    end
  end

  // Sticky until reset; observation only, the datapath ignores it.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q <= 1'b0;
    end else if (|err_s) begin
      err_q <= 1'b1;
    end
  end

  assign oerr = err_q;
`else
  logic unused_full_s;
  assign unused_full_s = ^full_s;
  assign oerr          = 1'b0;
`endif

endmodule

// File: tb/tb_inputc.sv
// Directed bench for inputc: a scoreboard of expected flits per VC is filled by
// the stimulus and drained by a monitor that checks every dequeued flit and ack.
module tb_inputc;
  import inputc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_;
  logic [15:0] idata;
  logic        ivalid;
  logic        ivch;
  logic [1:0]  ilck;
  logic [1:0]  ideq;
  logic [1:0]  olck, oack, ovalid, ohead;
  logic [15:0] odata0, odata1;
  logic        oerr;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          model_cnt [2];
  int          pre_cnt [2];
  int          ack_cnt [2];
  logic [1:0]  exp_ack;

  always #5 clk = ~clk;

  inputc #(.ROUTERID(0), .PCHID(0), .DEPTH(4)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .idata  (idata),
    .ivalid (ivalid),
    .ivch   (ivch),
    .ilck   (ilck),
    .olck   (olck),
    .oack   (oack),
    .odata0 (odata0),
    .odata1 (odata1),
    .ovalid (ovalid),
    .ohead  (ohead),
    .ideq   (ideq),
    .oerr   (oerr)
  );

  function automatic logic [15:0] mk(input flit_type_e t, input logic [12:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model tracks accepted flits and occupancy.
  task automatic cyc(input logic wv, input logic wc, input logic [15:0] wd, input logic [1:0] dq);
    logic acc;
    pre_cnt = model_cnt;
    acc = wv && (model_cnt[wc] < 4);
    for (int v = 0; v < 2; v++) if (dq[v] && model_cnt[v] > 0) model_cnt[v]--;
    if (acc) begin
      model_cnt[wc]++;
      if (wc == 1'b0) exp_q0.push_back(wd);
      else exp_q1.push_back(wd);
    end
    ivalid = wv; ivch = wc; idata = wd; ideq = dq;
    @(posedge clk); #1;
    ivalid = 1'b0; ideq = 2'b00;
  endtask

  task automatic monitor();
    logic [15:0] e, a;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        exp_ack = 2'b00;
      end else begin
        for (int v = 0; v < 2; v++) begin
          if (exp_ack[v] || oack[v]) chk($sformatf("oack%0d", v), 32'(oack[v]), 32'(exp_ack[v]));
          if (oack[v]) ack_cnt[v]++;
        end
        for (int v = 0; v < 2; v++) begin
          exp_ack[v] = ideq[v] && (pre_cnt[v] > 0);
          if (ideq[v]) begin
            chk($sformatf("ovalid%0d_at_deq", v), 32'(ovalid[v]), 32'(pre_cnt[v] > 0));
            if (pre_cnt[v] > 0) begin
              if ((v == 0 && exp_q0.size() == 0) || (v == 1 && exp_q1.size() == 0)) begin
                chk($sformatf("sb_underflow%0d", v), 32'd1, 32'd0);
              end else begin
                if (v == 0) begin e = exp_q0.pop_front(); a = odata0; end
                else begin e = exp_q1.pop_front(); a = odata1; end
                chk($sformatf("odata%0d", v), 32'(a), 32'(e));
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst_ = 1'b0; ivalid = 1'b0; ivch = 1'b0; idata = 16'h0000; ilck = 2'b00; ideq = 2'b00;
    exp_ack = 2'b00;
    for (int v = 0; v < 2; v++) begin model_cnt[v] = 0; pre_cnt[v] = 0; ack_cnt[v] = 0; end
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_olck", 32'(olck), 32'd0);
    chk("rst_oack", 32'(oack), 32'd0);
    chk("rst_oerr", 32'(oerr), 32'd0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // single HEADTAIL on VC0
    cyc(1'b1, 1'b0, mk(TYPE_HEADTAIL, 13'h1A1), 2'b00);
    chk("t1_ovalid", 32'(ovalid), 32'd1);
    chk("t1_ohead", 32'(ohead), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 2'b01);
    chk("t1_oack", 32'(oack), 32'd1);
    chk("t1_ovalid_empty", 32'(ovalid), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 2'b00);
    chk("t1_oack_once", 32'(oack), 32'd0);

    // full packet on VC1 plus one dropped write
    cyc(1'b1, 1'b1, mk(TYPE_HEAD, 13'h0B01), 2'b00);
    cyc(1'b1, 1'b1, mk(TYPE_BODY, 13'h0B02), 2'b00);
    cyc(1'b1, 1'b1, mk(TYPE_BODY, 13'h0B03), 2'b00);
    cyc(1'b1, 1'b1, mk(TYPE_TAIL, 13'h0B04), 2'b00);
    chk("t2_ovalid", 32'(ovalid), 32'd2);
    chk("t2_ohead", 32'(ohead), 32'd2);
    chk("t2_olck", 32'(olck[1]), 32'd1);
    cyc(1'b1, 1'b1, mk(TYPE_BODY, 13'h0BAD), 2'b00);
    chk("t2_ovalid_full", 32'(ovalid), 32'd2);
`ifdef INPUTC_ERRCHK_EN
    chk("t2_oerr", 32'(oerr), 32'd1);
`else
    chk("t2_oerr", 32'(oerr), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 2'b10);
      chk($sformatf("t2_ohead_deq%0d", i), 32'(ohead[1]), 32'd0);
    end
    chk("t2_ovalid_drained", 32'(ovalid[1]), 32'd0);
    cyc(1'b1, 1'b1, mk(TYPE_HEADTAIL, 13'h0B05), 2'b00);
    chk("t2_ohead_idle", 32'(ohead), 32'd2);
    cyc(1'b0, 1'b0, 16'h0000, 2'b10);

    // simultaneous write and dequeue on VC0
    cyc(1'b1, 1'b0, mk(TYPE_HEADTAIL, 13'h0301), 2'b00);
    cyc(1'b1, 1'b0, mk(TYPE_HEADTAIL, 13'h0302), 2'b00);
    cyc(1'b1, 1'b0, mk(TYPE_HEADTAIL, 13'h0303), 2'b01);
    chk("t3_ohead", 32'(ohead[0]), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 2'b01);
    chk("t3_ovalid_one_left", 32'(ovalid[0]), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 2'b01);
    chk("t3_ovalid_empty", 32'(ovalid[0]), 32'd0);

    // pointer wrap: ten packets through a one-cycle write/dequeue pipeline
    for (int i = 0; i <= 10; i++) begin
      cyc(i < 10, 1'b0, mk(TYPE_HEADTAIL, 13'(13'h0400 + i)), (i > 0) ? 2'b01 : 2'b00);
    end
    cyc(1'b0, 1'b0, 16'h0000, 2'b00);
    chk("t4_ovalid_empty", 32'(ovalid), 32'd0);
    chk("t4_olck_clear", 32'(olck), 32'd0);

    // lock held by upstream until ilck drops
    ilck = 2'b10;
    cyc(1'b1, 1'b1, mk(TYPE_HEAD, 13'h0C01), 2'b00);
    chk("t5_olck_set", 32'(olck), 32'd2);
    cyc(1'b1, 1'b1, mk(TYPE_TAIL, 13'h0C02), 2'b00);
    cyc(1'b0, 1'b0, 16'h0000, 2'b10);
    cyc(1'b0, 1'b0, 16'h0000, 2'b10);
    cyc(1'b0, 1'b0, 16'h0000, 2'b00);
    chk("t5_olck_held", 32'(olck), 32'd2);
    ilck = 2'b00;
    cyc(1'b0, 1'b0, 16'h0000, 2'b00);
    chk("t5_olck_clear", 32'(olck), 32'd0);

    // asynchronous reset with three flits resident and an ack in flight
    cyc(1'b1, 1'b0, mk(TYPE_HEAD, 13'h0D01), 2'b00);
    cyc(1'b1, 1'b0, mk(TYPE_BODY, 13'h0D02), 2'b00);
    cyc(1'b1, 1'b0, mk(TYPE_BODY, 13'h0D03), 2'b00);
    cyc(1'b1, 1'b0, mk(TYPE_BODY, 13'h0D04), 2'b00);
    cyc(1'b0, 1'b0, 16'h0000, 2'b01);
    chk("t6_pre_oack", 32'(oack), 32'd1);
    #2;
    rst_ = 1'b0;
    #1;
    chk("t6_ovalid", 32'(ovalid), 32'd0);
    chk("t6_olck", 32'(olck), 32'd0);
    chk("t6_oack", 32'(oack), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    for (int v = 0; v < 2; v++) begin model_cnt[v] = 0; pre_cnt[v] = 0; end
    @(posedge clk); #1;
    rst_ = 1'b1;
    cyc(1'b1, 1'b0, mk(TYPE_HEADTAIL, 13'h0555), 2'b00);
    chk("t6_ohead_after_rst", 32'(ohead), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 2'b01);
    cyc(1'b0, 1'b0, 16'h0000, 2'b00);

    chk("ack_total_vc0", 32'(ack_cnt[0]), 32'd15);
    chk("ack_total_vc1", 32'(ack_cnt[1]), 32'd7);
    chk("sb_left_vc0", 32'(exp_q0.size()), 32'd0);
    chk("sb_left_vc1", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inputc.md
Name: inputc

Overview:
- Router input channel: the stage directly downstream of a neighbouring router's output channel across one physical link.
- Accepts flits tagged with a virtual channel, buffers them in per-VC FIFOs and presents each VC's head-of-line flit to the switch stage.
- Returns per-VC credit acks and per-VC lock status upstream, which drive the upstream output channel's credit counters and VC lock.

Parameters:
ROUTERID, 0, router identifier (debug/trace only)
PCHID, 0, physical channel identifier (debug/trace only)
DEPTH, `FIFO_P1 (4), flits per VC FIFO; must equal the upstream credit depth

Ports:
clk  in  1  clock; all state updates on posedge
rst_  in  1  asynchronous active-low reset (`Enable_ = 0)
idata  in  `DATAW+1  flit from link; type field at [`TYPE_MSB:`TYPE_LSB]
ivalid  in  1  flit valid this cycle
ivch  in  `VCHW+1  target VC of idata
ilck  in  `VCH+1  upstream VC lock status (upstream olck)
olck  out  `VCH+1  VC busy: packet resident or in transit
oack  out  `VCH+1  one-cycle credit return per dequeued flit
odata0  out  `DATAW+1  head-of-line flit, VC0
odata1  out  `DATAW+1  head-of-line flit, VC1
ovalid  out  `VCH+1  VC FIFO non-empty
ohead  out  `VCH+1  head-of-line flit is HEAD/HEADTAIL and VC FSM is IDLE (switch-allocation request)
ideq  in  `VCH+1  switch dequeues head-of-line flit of that VC
oerr  out  1  sticky protocol error (optional feature only)

Behaviour:
- Reset (async, immediate): FIFOs empty, all pointers and counts 0, olck=0, oack=0, FSMs IDLE, oerr=0. odata0/odata1 are don't-care while ovalid=0.
- Write: when ivalid=1, idata is written to FIFO[ivch] at the rising edge. It is visible on odata/ovalid the next cycle (1-cycle latency).
- Read: when ideq[v]=1 and ovalid[v]=1, the read pointer advances. ideq on an empty VC is ignored: no ack, no state change.
- Simultaneous write and read on the same VC: both take effect; count is unchanged.
- Full: a write to a full VC is dropped and pointers are unchanged. The credit protocol makes this unreachable in normal operation.
- Count width: `FIFOD_P1+1 bits, range 0..DEPTH. Pointers are `FIFOD_P1 bits and wrap modulo DEPTH.
- oack[v]: registered. It is 1 in the cycle after each successful dequeue, otherwise 0. One pulse per flit; back-to-back dequeues produce back-to-back pulses.
- Per-VC FSM:
  - IDLE -> ACTIVE on dequeue of a HEAD flit.
  - IDLE stays IDLE on dequeue of HEADTAIL.
  - ACTIVE -> IDLE on dequeue of TAIL.
  - BODY dequeues hold ACTIVE.
- olck[v]: registered.
  - Set when a flit is written to VC v, or when ovalid[v] or FSM ACTIVE.
  - Otherwise cleared when ilck[v]=0.
  - Held while ilck[v]=1.
- ohead is combinational from the FIFO head type and FSM state.
- Reset asserted mid-packet: all buffered flits are discarded and no acks are issued.

Optional Feature:
- Macro: INPUTC_ERRCHK_EN.
- Defined: oerr is set and held until reset on any of:
  - write to a full VC;
  - BODY/TAIL dequeued while FSM IDLE;
  - HEAD/HEADTAIL dequeued while FSM ACTIVE.
  - In all cases the datapath behaviour is unchanged.
- Undefined: oerr is tied to 0 and no checker logic is synthesised.

Decomposition:
- Shared definitions in define.h: TYPE_HEAD/BODY/TAIL/HEADTAIL/NONE, TYPE_MSB/LSB, DATAW, VCH, VCHW, FIFO_P1, FIFOD_P1, Enable/Enable_.
- Sub-module inputc_fifo: one synchronous single-VC FIFO with count, full and empty, instantiated once per VC.
- FSM, ack and lock logic live in inputc.

Test Plan:
- Reset and single flit: reset, then HEADTAIL on VC0 at cycle 0 -> ovalid[0]=1 and ohead[0]=1 at cycle 1. ideq[0] at cycle 1 -> oack[0]=1 at cycle 2 only; ovalid[0]=0.
- Full packet: HEAD, BODY, BODY, TAIL on VC1 with no dequeue -> count 4, ovalid[1]=1. Extra write is dropped (oerr=1 if INPUTC_ERRCHK_EN). Four dequeues -> four oack[1] pulses, FSM back to IDLE, ohead[1] toggles only on the HEAD.
- Simultaneous: VC0 holds 2 flits; write and dequeue VC0 in the same cycle -> count stays 2, one oack pulse, FIFO order preserved.
- Pointer wrap: stream 10 single-flit packets through VC0 with a 1-cycle write/dequeue pipeline -> data out equals data in, 10 acks, no loss.
- Lock: write HEAD on VC1 with ilck[1]=1 -> olck[1]=1. Drain the packet, then drop ilck[1] -> olck[1]=0 one cycle later. VC0 olck stays 0 throughout.
- Async reset mid-packet: assert rst_ between clock edges with VC0 holding 3 flits -> ovalid=0, olck=0 and oack=0 immediately, with no clock edge required.
